// File: rtl/mfsk_modulator.sv
// M-ary continuous-phase FSK modulator.
// Each word is sent MSB-first as BPS-bit symbols, each SYM_LEN samples long.
module mfsk_modulator #(
   parameter int DATA_W = 8,
   parameter int BPS = 1,
   parameter int PHASE_W = 16,
   parameter int SAMPLE_W = 8,
   parameter int SYM_LEN = 64,
   parameter int SAMPLE_DIV = 1,
   parameter logic [PHASE_W-1:0] F0_FTW = 16'h0400,
   parameter logic [PHASE_W-1:0] FTW_STEP = 16'h0400
) (
   input  logic                clk,
   input  logic                reset,
   input  logic [DATA_W-1:0]   parallel_in,
   input  logic                load,
   output logic                ready,
   output logic [SAMPLE_W-1:0] mod_out,
   output logic                sample_valid,
   output logic [BPS-1:0]      sym_out,
   output logic                word_done
);

   localparam int NSYM = DATA_W / BPS;
   localparam int SYM_CW = $clog2(NSYM + 1);
   localparam int SMP_CW = $clog2(SYM_LEN);
   localparam int DIV_CW = $clog2(SAMPLE_DIV + 1);
   localparam longint AMP = (64'sd1 <<< (SAMPLE_W - 1)) - 64'sd1;

   // Elaboration-time sine in Q30 fixed point (quarter-wave Taylor series).
   function automatic logic [SAMPLE_W-1:0] sine_at(input int idx);
      longint x;
      longint x2;
      longint term;
      longint acc;
      int k;
      k = idx % 128;
      if (k > 64) k = 128 - k;
      x = (64'sd3373259426 * longint'(k)) / 64'sd128;
      x2 = (x * x) >>> 30;
      term = x;
      acc = x;
      for (int n = 1; n <= 8; n++) begin
         term = -((term * x2) >>> 30) / longint'((2 * n) * (2 * n + 1));
         acc = acc + term;
      end
      acc = (acc * AMP + (64'sd1 <<< 29)) >>> 30;
      if (idx >= 128) acc = -acc;
      return acc[SAMPLE_W-1:0];
   endfunction

   logic [SAMPLE_W-1:0] lut [256];

   for (genvar g = 0; g < 256; g++) begin : g_lut
      localparam logic [SAMPLE_W-1:0] V = sine_at(g);
      assign lut[g] = V;
   end

   typedef enum logic {IDLE, RUN} state_t;

   state_t              state;
   state_t              state_nx;
   logic                tick;
   logic                sym_end;
   logic                last;
   logic                accept;
   logic [DIV_CW-1:0]   div_cnt;
   logic [SMP_CW-1:0]   smp_cnt;
   logic [SYM_CW-1:0]   sym_cnt;
   logic [DATA_W-1:0]   shreg;
   logic [PHASE_W-1:0]  phase;
   logic [PHASE_W-1:0]  ftw;

   assign sym_out = shreg[DATA_W-1 -: BPS];
   assign ftw = F0_FTW + PHASE_W'(sym_out) * FTW_STEP;

   always_comb begin
      tick = (state == RUN) && (div_cnt == DIV_CW'(SAMPLE_DIV - 1));
      sym_end = tick && (smp_cnt == SMP_CW'(SYM_LEN - 1));
      last = sym_end && (sym_cnt == SYM_CW'(NSYM - 1));
      ready = (state == IDLE) || last;
      accept = load && ready;
      state_nx = state;
      if (accept) state_nx = RUN;
      else if (last) state_nx = IDLE;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state <= IDLE;
      else state <= state_nx;
   end

   // Phase is never cleared between symbols or words: continuous phase.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         div_cnt <= '0;
         smp_cnt <= '0;
         sym_cnt <= '0;
         shreg <= '0;
         phase <= '0;
         mod_out <= '0;
         sample_valid <= 1'b0;
         word_done <= 1'b0;
      end else begin
         sample_valid <= tick;
         word_done <= last;
         if (tick) begin
            mod_out <= lut[phase[PHASE_W-1 -: 8]];
            phase <= phase + ftw;
         end
         if (accept) begin
            shreg <= parallel_in;
            sym_cnt <= '0;
            smp_cnt <= '0;
            div_cnt <= '0;
         end else if (tick) begin
            div_cnt <= '0;
            if (sym_end) begin
               smp_cnt <= '0;
               sym_cnt <= sym_cnt + 1'b1;
               shreg <= shreg << BPS;
            end else begin
               smp_cnt <= smp_cnt + 1'b1;
            end
         end else if (state == RUN) begin
            div_cnt <= div_cnt + 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_mfsk_modulator.sv
// Bench for mfsk_modulator: two instances (BPS=1/DIV=1 and BPS=2/DIV=4)
// checked every cycle against a sample-index model plus literal samples.
module tb_mfsk_modulator;

   localparam int DW = 8;
   localparam int SL = 64;

   logic       clk = 1'b0;
   logic       rst0 = 1'b0;
   logic       rst1 = 1'b0;
   logic       load0 = 1'b0;
   logic       load1 = 1'b0;
   logic [7:0] din0 = '0;
   logic [7:0] din1 = '0;
   logic       ready0, ready1, val0, val1, done0, done1;
   logic [7:0] mod0, mod1;
   logic       sym0;
   logic [1:0] sym1;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   mfsk_modulator u_dut0 (
      .clk(clk), .reset(rst0), .parallel_in(din0), .load(load0),
      .ready(ready0), .mod_out(mod0), .sample_valid(val0),
      .sym_out(sym0), .word_done(done0)
   );

   mfsk_modulator #(.BPS(2), .SAMPLE_DIV(4)) u_dut1 (
      .clk(clk), .reset(rst1), .parallel_in(din1), .load(load1),
      .ready(ready1), .mod_out(mod1), .sample_valid(val1),
      .sym_out(sym1), .word_done(done1)
   );

   function automatic int bp(input int u);
      return (u == 0) ? 1 : 2;
   endfunction

   function automatic int dv(input int u);
      return (u == 0) ? 1 : 4;
   endfunction

   function automatic int nsym(input int u);
      return DW / bp(u);
   endfunction

   function automatic int symbol(input int u, input int w, input int k);
      return (w >> (DW - bp(u) * (k + 1))) & ((1 << bp(u)) - 1);
   endfunction

   function automatic int sine(input int i);
      real v;
      v = 127.0 * $sin(2.0 * 3.141592653589793 * i / 256.0);
      if (v >= 0.0) return int'($floor(v + 0.5));
      return -int'($floor(-v + 0.5));
   endfunction

   // Model: t counts clocks since the word was accepted.
   bit busy [2];
   int t [2];
   int word [2];
   int ph [2];
   int e_mod [2];
   bit e_val [2];
   bit e_done [2];

   task automatic step(input int u, input logic r, input logic ld,
                       input logic [7:0] d);
      bit tk;
      bit lst;
      int n;
      int s;
      if (!r) begin
         busy[u] = 0;
         t[u] = 0;
         word[u] = 0;
         ph[u] = 0;
         e_mod[u] = 0;
         e_val[u] = 0;
         e_done[u] = 0;
      end else begin
         tk = busy[u] && (t[u] % dv(u) == dv(u) - 1);
         n = t[u] / dv(u);
         lst = tk && (n == nsym(u) * SL - 1);
         e_val[u] = tk;
         e_done[u] = lst;
         if (tk) begin
            s = symbol(u, word[u], n / SL);
            e_mod[u] = sine((ph[u] >> 8) & 255);
            ph[u] = (ph[u] + 'h400 + s * 'h400) & 'hFFFF;
         end
         if (ld && (!busy[u] || lst)) begin
            busy[u] = 1;
            t[u] = 0;
            word[u] = int'(d);
         end else if (lst) begin
            busy[u] = 0;
         end else if (busy[u]) begin
            t[u]++;
         end
      end
   endtask

   function automatic int m_ready(input int u);
      if (!busy[u]) return 1;
      return (t[u] % dv(u) == dv(u) - 1) &&
             (t[u] / dv(u) == nsym(u) * SL - 1);
   endfunction

   function automatic int m_sym(input int u);
      if (!busy[u]) return 0;
      return symbol(u, word[u], (t[u] / dv(u)) / SL);
   endfunction

   always @(posedge clk or negedge rst0) step(0, rst0, load0, din0);
   always @(posedge clk or negedge rst1) step(1, rst1, load1, din1);

   task automatic chk(input string nm, input int u, input int act,
                      input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s u%0d: got %0d, want %0d", nm, u, act, exp);
      end
   endtask

   int cnt_val0 = 0, cnt_val1 = 0;
   int cnt_done0 = 0, cnt_done1 = 0;
   int done_at0 = 0;
   int run0 = 0, max_run0 = 0;
   int last_sym0 = 0, last_sym1 = 0;
   int samp0 [$];
   int samp1 [$];
   int symq0 [$];
   int symq1 [$];

   always @(negedge clk) begin
      chk("ready", 0, int'(ready0), m_ready(0));
      chk("mod_out", 0, int'($signed(mod0)), e_mod[0]);
      chk("sample_valid", 0, int'(val0), int'(e_val[0]));
      chk("word_done", 0, int'(done0), int'(e_done[0]));
      chk("sym_out", 0, int'(sym0), m_sym(0));
      chk("ready", 1, int'(ready1), m_ready(1));
      chk("mod_out", 1, int'($signed(mod1)), e_mod[1]);
      chk("sample_valid", 1, int'(val1), int'(e_val[1]));
      chk("word_done", 1, int'(done1), int'(e_done[1]));
      chk("sym_out", 1, int'(sym1), m_sym(1));
      if (val0) begin
         cnt_val0++;
         samp0.push_back(int'($signed(mod0)));
         run0++;
      end else begin
         run0 = 0;
      end
      if (run0 > max_run0) max_run0 = run0;
      if (done0) begin
         cnt_done0++;
         done_at0 = cnt_val0;
      end
      if (val1) begin
         cnt_val1++;
         samp1.push_back(int'($signed(mod1)));
      end
      if (done1) cnt_done1++;
      if (int'(sym0) != last_sym0) begin
         last_sym0 = int'(sym0);
         symq0.push_back(last_sym0);
      end
      if (int'(sym1) != last_sym1) begin
         last_sym1 = int'(sym1);
         symq1.push_back(last_sym1);
      end
   end

   task automatic clear_stats();
      cnt_val0 = 0;
      cnt_val1 = 0;
      cnt_done0 = 0;
      cnt_done1 = 0;
      done_at0 = 0;
      max_run0 = 0;
      samp0.delete();
      samp1.delete();
      symq0.delete();
      symq1.delete();
   endtask

   initial begin
      repeat (3) @(posedge clk);
      #1;
      chk("rst_ready", 0, int'(ready0), 1);
      chk("rst_mod", 0, int'(mod0), 0);
      chk("rst_ready", 1, int'(ready1), 1);
      chk("rst_sym", 1, int'(sym1), 0);
      rst0 = 1'b1;
      rst1 = 1'b1;
      clear_stats();
      repeat (10) @(posedge clk);
      #1;
      chk("idle_valid", 0, cnt_val0, 0);
      chk("idle_valid", 1, cnt_val1, 0);
      chk("idle_mod", 0, int'(mod0), 0);

      // single word, BPS=1
      clear_stats();
      load0 = 1'b1;
      din0 = 8'b1001_1001;
      @(posedge clk);
      #1;
      load0 = 1'b0;
      repeat (530) @(posedge clk);
      #1;
      chk("n_valid", 0, cnt_val0, 512);
      chk("n_done", 0, cnt_done0, 1);
      chk("done_at", 0, done_at0, 512);
      chk("n_symchg", 0, symq0.size(), 6);
      for (int i = 0; i < 6 && i < symq0.size(); i++)
         chk("symchg", 0, symq0[i], (i % 2 == 0) ? 1 : 0);
      if (samp0.size() >= 66) begin
         chk("s0", 0, samp0[0], 0);
         chk("s1", 0, samp0[1], 25);
         chk("s2", 0, samp0[2], 49);
         chk("s64", 0, samp0[64], 0);
         chk("s65", 0, samp0[65], 12);
      end else begin
         chk("samples_short", 0, samp0.size(), 66);
      end

      // back-to-back words with load held high
      clear_stats();
      load0 = 1'b1;
      din0 = 8'hA5;
      @(posedge clk);
      #1;
      din0 = 8'h3C;
      repeat (512) @(posedge clk);
      #1;
      load0 = 1'b0;
      repeat (530) @(posedge clk);
      #1;
      chk("b2b_valid", 0, cnt_val0, 1024);
      chk("b2b_run", 0, max_run0, 1024);
      chk("b2b_done", 0, cnt_done0, 2);

      // BPS=2, SAMPLE_DIV=4, load while busy ignored
      clear_stats();
      load1 = 1'b1;
      din1 = 8'b11_01_00_10;
      @(posedge clk);
      #1;
      load1 = 1'b0;
      repeat (40) @(posedge clk);
      #1;
      load1 = 1'b1;
      din1 = 8'hFF;
      @(posedge clk);
      #1;
      load1 = 1'b0;
      repeat (1040) @(posedge clk);
      #1;
      chk("n_valid", 1, cnt_val1, 256);
      chk("n_done", 1, cnt_done1, 1);
      chk("n_symchg", 1, symq1.size(), 5);
      if (symq1.size() >= 5) begin
         chk("symchg0", 1, symq1[0], 3);
         chk("symchg1", 1, symq1[1], 1);
         chk("symchg2", 1, symq1[2], 0);
         chk("symchg3", 1, symq1[3], 2);
      end
      if (samp1.size() >= 194) begin
         chk("s1", 1, samp1[1], 49);
         chk("s2", 1, samp1[2], 90);
         chk("s64", 1, samp1[64], 0);
         chk("s65", 1, samp1[65], 25);
         chk("s129", 1, samp1[129], 12);
         chk("s193", 1, samp1[193], 37);
      end else begin
         chk("samples_short", 1, samp1.size(), 194);
      end

      // reset mid-word aborts it
      clear_stats();
      load1 = 1'b1;
      din1 = 8'h5A;
      @(posedge clk);
      #1;
      load1 = 1'b0;
      for (int i = 0; i < 2000 && cnt_val1 < 100; i++) @(posedge clk);
      chk("reach_s100", 1, cnt_val1, 100);
      #2;
      rst1 = 1'b0;
      #1;
      chk("abort_mod", 1, int'(mod1), 0);
      chk("abort_valid", 1, int'(val1), 0);
      chk("abort_ready", 1, int'(ready1), 1);
      chk("abort_sym", 1, int'(sym1), 0);
      repeat (3) @(posedge clk);
      #1;
      rst1 = 1'b1;
      repeat (1100) @(posedge clk);
      #1;
      chk("abort_done", 1, cnt_done1, 0);
      chk("abort_idle_ready", 1, int'(ready1), 1);
      chk("abort_idle_valid", 1, cnt_val1, 100);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
